// File: rtl/sink_arbiter.sv
// Round-robin arbiter that funnels PORTS egress streams into one registered sink stage and flags when every port has delivered LIMIT flits.
// Optional accept trace: define SINK_ARB_TRACE_EN (simulation only; prints to stdout).
module sink_arbiter #(
    parameter int WIDTH   = 32,
    parameter int PORTS   = 4,
    parameter int P_WIDTH = $clog2(PORTS),
    parameter int LIMIT   = 100
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PORTS*WIDTH-1:0]   data_in,
    input  logic [PORTS-1:0]         valid_in,
    output logic [PORTS-1:0]         ready_out,
    output logic [WIDTH-1:0]         data_out,
    output logic                     valid_out,
    input  logic                     ready_in,
    output logic [P_WIDTH-1:0]       grant_id,
    output logic                     done
);
    localparam logic [15:0]        LIMIT_C = 16'(LIMIT);
    localparam logic [P_WIDTH-1:0] LAST_C  = P_WIDTH'(PORTS - 1);

    logic [P_WIDTH-1:0] ptr_reg;
    logic [P_WIDTH-1:0] win;
    logic               any_valid;
    logic               load;
    logic               accept;
    logic [WIDTH-1:0]   flit [PORTS];
    logic [PORTS-1:0]   full;
    logic [WIDTH-1:0]   data_out_reg;
    logic [P_WIDTH-1:0] grant_id_reg;
    logic               valid_out_reg;
    logic               done_reg;

    // First requester at or after ptr, wrapping modulo PORTS.
    always_comb begin
        win       = '0;
        any_valid = 1'b0;
        for (int k = 0; k < PORTS; k++) begin
            int idx;
            idx = int'(ptr_reg) + k;
            if (idx >= PORTS) idx = idx - PORTS;
            if (!any_valid && valid_in[idx]) begin
                any_valid = 1'b1;
                win       = P_WIDTH'(idx);
            end
        end
    end

    assign load   = !valid_out_reg || ready_in;
    // Requests are ignored while reset is held so nothing is handshaken away.
    assign accept = rst && load && any_valid;

    generate
        for (genvar gi = 0; gi < PORTS; gi++) begin : g_port
            logic [15:0] cnt_reg;

            assign flit[gi]      = data_in[gi*WIDTH +: WIDTH];
            assign ready_out[gi] = accept && (win == P_WIDTH'(gi));
            assign full[gi]      = (cnt_reg == LIMIT_C);

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_reg <= '0;
                end else if (ready_out[gi] && !full[gi]) begin
                    cnt_reg <= cnt_reg + 16'd1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_reg       <= '0;
            data_out_reg  <= '0;
            grant_id_reg  <= '0;
            valid_out_reg <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            if (load) begin
                if (any_valid) begin
                    data_out_reg  <= flit[win];
                    grant_id_reg  <= win;
                    valid_out_reg <= 1'b1;
                    ptr_reg       <= (win == LAST_C) ? '0 : win + 1'b1;
                end else begin
                    valid_out_reg <= 1'b0;
                end
            end
            done_reg <= &full;
        end
    end

    assign data_out  = data_out_reg;
    assign grant_id  = grant_id_reg;
    assign valid_out = valid_out_reg;
    assign done      = done_reg;

`ifdef SINK_ARB_TRACE_EN
    logic [15:0] cnt_view [PORTS];

    generate
        for (genvar gi = 0; gi < PORTS; gi++) begin : g_view
            assign cnt_view[gi] = g_port[gi].cnt_reg;
        end
    endgenerate

    always @(posedge clk) begin
        if (accept) begin
            $display("%0t port=%0d src=%h cnt=%0d", $time, win, flit[win],
                     full[win] ? cnt_view[win] : cnt_view[win] + 16'd1);
        end
    end
`endif

endmodule
